// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_pkg                                                 |
// | Purpose  : Shared widths, default halt encoding, fetch FSM state type and  |
// |            the {pc, inst} buffer entry layout used by the fetch stage.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package instr_fetch_pkg;

   localparam int XLEN    = 64;
   localparam int ILEN    = 32;
   localparam int ENTRY_W = XLEN + ILEN;

   // RISC-V EBREAK; default word that terminates execution.
   localparam logic [ILEN-1:0] EBREAK_INSN = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_WAIT_HALT = 2'd2,
      ST_HALT      = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Purpose  : Two-entry FIFO of {pc, inst} records between fetch and decode.  |
// | Ports    : clk_i/rst_i     clock, asynchronous active-high reset           |
// |            flush_i         discard all entries (wins over push/pop)        |
// |            push_i/push_data_i  enqueue one entry                           |
// |            pop_i           dequeue head entry                              |
// |            head_o          current head entry                              |
// |            full_o/empty_o  occupancy flags                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_fifo
   import instr_fetch_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] push_data_i,
   input  logic               pop_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic               full_o,
   output logic               empty_o
);

   logic [1:0][ENTRY_W-1:0] mem_q, mem_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic                    wr_ptr_q, wr_ptr_d;
   logic [1:0]              count_q, count_d;
   logic                    do_push;
   logic                    do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only accepted alongside a pop; in that case
   // the write slot equals the head slot, whose old contents leave this cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch                                                     |
// | Purpose  : Instruction fetch stage. Walks the PC through a combinational   |
// |            instruction ROM, buffers up to two {pc, inst} records for       |
// |            decode, honours redirects and stops on the halt instruction.    |
// | Ports    : clk_i, rst_i        clock, asynchronous active-high reset       |
// |            start_i             pulse: begin fetching at RESET_PC           |
// |            rom_addr_o/rom_data_i  ROM address / returned word             |
// |            rom_finish_o, halted_o  high only once halted                   |
// |            inst_o, pc_o, valid_o, ready_i  decode handshake                |
// |            redirect_i, redirect_pc_i  branch/jump redirect                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 64'h0000_0000_0000_0000,
   parameter logic [ILEN-1:0] HALT_INSN = EBREAK_INSN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic [XLEN-1:0] rom_addr_o,
   input  logic [ILEN-1:0] rom_data_i,
   output logic            rom_finish_o,
   output logic [ILEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic            valid_o,
   input  logic            ready_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            halted_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;

   fetch_entry_t    head_entry;
   fetch_entry_t    push_entry;
   logic            fifo_full;
   logic            fifo_empty;
   logic            deq;
   logic            redirect_take;
   logic            fire;

   assign valid_o       = !fifo_empty && (state_q != ST_HALT);
   assign inst_o        = head_entry.inst;
   assign pc_o          = head_entry.pc;
   assign rom_addr_o    = pc_q;
   assign rom_finish_o  = (state_q == ST_HALT);
   assign halted_o      = rom_finish_o;

   assign deq           = valid_o && ready_i;
   assign redirect_take = redirect_i && ((state_q == ST_RUN) || (state_q == ST_WAIT_HALT));
   // A full buffer still accepts a new word when decode drains the head.
   assign fire          = (state_q == ST_RUN) && !redirect_take && (!fifo_full || deq);

   assign push_entry.pc   = pc_q;
   assign push_entry.inst = rom_data_i;

   fetch_fifo u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (redirect_take),
      .push_i      (fire),
      .push_data_i (push_entry),
      .pop_i       (deq),
      .head_o      (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
            end
         end
         ST_RUN: begin
            if (redirect_take) begin
               pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (fire) begin
               pc_d = pc_q + 64'd4;
               if (rom_data_i == HALT_INSN) begin
                  state_d = ST_WAIT_HALT;
               end
            end
         end
         ST_WAIT_HALT: begin
            if (redirect_take) begin
               state_d = ST_RUN;
               pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (deq && (head_entry.inst == HALT_INSN)) begin
               // Fetch stopped at the halt word, so it is the last entry.
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

endmodule
`default_nettype wire
